// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit. Holds the FSM
//               state encoding, the funct3 access-size constants, and helper
//               functions that classify an access and pick its byte lane.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    function automatic logic is_byte(input logic [2:0] funct3);
        return (funct3 == c_F3_LB) || (funct3 == c_F3_LBU);
    endfunction

    function automatic logic is_half(input logic [2:0] funct3);
        return (funct3 == c_F3_LH) || (funct3 == c_F3_LHU);
    endfunction

    // Byte lane used by the access. Half/word ignore the low address bits
    // that would make them misaligned, so a misaligned access that does reach
    // memory still uses a naturally aligned lane. Reserved codes act as word.
    function automatic logic [1:0] lane_offset(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic [1:0] off;
        case (funct3)
            c_F3_LB, c_F3_LBU: off = addr_lo;
            c_F3_LH, c_F3_LHU: off = {addr_lo[1], 1'b0};
            c_F3_LW:           off = 2'b00;
            default:           off = 2'b00;
        endcase
        return off;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        if (is_byte(funct3))      mis = 1'b0;
        else if (is_half(funct3)) mis = addr_lo[0];
        else                      mis = (addr_lo != 2'b00);
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational lane logic for the load/store unit.
//               Store side builds the byte-lane mask and lane-replicated write
//               data; load side shifts the read word down to the addressed
//               lane and sign/zero-extends it.
// Ports       : i_st_addr_lo/i_st_funct3/i_st_wdata -> o_st_mask/o_st_wdata
//               i_ld_addr_lo/i_ld_funct3/i_ld_rdata -> o_ld_data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_addr_lo,
    input  logic [2:0]  i_st_funct3,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_mask,
    output logic [31:0] o_st_wdata,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [2:0]  i_ld_funct3,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [1:0]  w_st_off;
    logic [1:0]  w_ld_off;
    logic [31:0] w_ld_shift;
    logic        w_ld_signed;

    assign w_st_off    = lane_offset(i_st_funct3, i_st_addr_lo);
    assign w_ld_off    = lane_offset(i_ld_funct3, i_ld_addr_lo);
    assign w_ld_shift  = i_ld_rdata >> {w_ld_off, 3'b000};
    // funct3[2] marks the unsigned byte/half variants
    assign w_ld_signed = ~i_ld_funct3[2];

    always_comb begin
        o_st_mask  = 4'b1111;
        o_st_wdata = i_st_wdata;
        if (is_byte(i_st_funct3)) begin
            o_st_mask  = 4'b0001 << w_st_off;
            o_st_wdata = {4{i_st_wdata[7:0]}};
        end else if (is_half(i_st_funct3)) begin
            o_st_mask  = 4'b0011 << w_st_off;
            o_st_wdata = {2{i_st_wdata[15:0]}};
        end
    end

    always_comb begin
        o_ld_data = w_ld_shift;
        if (is_byte(i_ld_funct3)) begin
            o_ld_data = {{24{w_ld_signed & w_ld_shift[7]}}, w_ld_shift[7:0]};
        end else if (is_half(i_ld_funct3)) begin
            o_ld_data = {{16{w_ld_signed & w_ld_shift[15]}}, w_ld_shift[15:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Multi-cycle load/store unit. Accepts one access at a time
//               from the pipeline, runs a req/ready + rvalid handshake with
//               data memory and returns extended load data with a one-cycle
//               o_done pulse.
// Config      : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//               accesses skip memory and complete with o_misaligned=1.
// Ports       : i_clk, i_rst (sync, active high)
//               pipeline : i_valid/o_ready, i_load, i_store, i_funct3,
//                          i_addr, i_wdata, o_done, o_rdata, o_misaligned
//               memory   : o_dmem_req/addr/ren/wen/mask/wdata,
//                          i_dmem_ready, i_dmem_rvalid, i_dmem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_load,
    input  logic              i_store,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned,
    output logic              o_dmem_req,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic              o_dmem_ren,
    output logic              o_dmem_wen,
    output logic [3:0]        o_dmem_mask,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_ready,
    input  logic              i_dmem_rvalid,
    input  logic [31:0]       i_dmem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_state_next;
    logic              r_is_load;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [3:0]        r_dmem_mask;
    logic [31:0]       r_dmem_wdata;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_access;
    logic              w_trap;
    logic [3:0]        w_st_mask;
    logic [31:0]       w_st_wdata;
    logic [31:0]       w_ld_data;

    assign w_accept = i_valid && (r_state == IDLE) && !i_rst;
    assign w_access = i_load | i_store;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misaligned;
    assign w_trap       = w_access && is_misaligned(i_funct3, i_addr[1:0]);
    assign o_misaligned = (r_state == DONE) && r_misaligned;
`else
    assign w_trap       = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    // Store lanes come from the incoming request so they can be registered
    // at accept; load extraction uses the latched address/size.
    lsu_align u_align (
        .i_st_addr_lo (i_addr[1:0]),
        .i_st_funct3  (i_funct3),
        .i_st_wdata   (i_wdata),
        .o_st_mask    (w_st_mask),
        .o_st_wdata   (w_st_wdata),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_funct3  (r_funct3),
        .i_ld_rdata   (i_dmem_rdata),
        .o_ld_data    (w_ld_data)
    );

    always_comb begin
        w_state_next = r_state;
        o_ready      = (r_state == IDLE) && !i_rst;
        o_done       = (r_state == DONE);
        o_dmem_req   = (r_state == REQ);
        o_dmem_ren   = (r_state == REQ) && r_is_load;
        o_dmem_wen   = (r_state == REQ) && r_is_store;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_access || w_trap) w_state_next = DONE;
                    else                     w_state_next = REQ;
                end
            end
            REQ: begin
                if (i_dmem_ready) w_state_next = r_is_store ? DONE : WAIT;
            end
            WAIT: begin
                if (i_dmem_rvalid) w_state_next = DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_dmem_addr  <= '0;
            r_dmem_mask  <= 4'b0000;
            r_dmem_wdata <= 32'h0;
            r_rdata      <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                // store has priority when both type bits are set
                r_is_store   <= i_store;
                r_is_load    <= i_load & ~i_store;
                r_funct3     <= i_funct3;
                r_addr_lo    <= i_addr[1:0];
                r_dmem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                r_dmem_mask  <= w_st_mask;
                r_dmem_wdata <= w_st_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                r_misaligned <= w_trap;
`endif
            end
            if ((r_state == WAIT) && i_dmem_rvalid) begin
                r_rdata <= w_ld_data;
            end
        end
    end

    assign o_rdata      = r_rdata;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_mask  = r_dmem_mask;
    assign o_dmem_wdata = r_dmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lsu
// Description : Self-checking bench for lsu. A table of access vectors is
//               driven through the pipeline port; a reactive memory model
//               answers with programmable ready/rvalid delays and checks the
//               request fields, while a scoreboard queue holds the expected
//               completion (latency, o_rdata, o_misaligned) for each access.
//               A hand-written sequence covers reset in the WAIT state.
// Config      : LSU_MISALIGN_TRAP_EN follows the same define as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_valid;
    logic              o_ready;
    logic              i_load;
    logic              i_store;
    logic [2:0]        i_funct3;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              o_done;
    logic [31:0]       o_rdata;
    logic              o_misaligned;
    logic              o_dmem_req;
    logic [ADDR_W-1:0] o_dmem_addr;
    logic              o_dmem_ren;
    logic              o_dmem_wen;
    logic [3:0]        o_dmem_mask;
    logic [31:0]       o_dmem_wdata;
    logic              i_dmem_ready;
    logic              i_dmem_rvalid;
    logic [31:0]       i_dmem_rdata;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(ADDR_W)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_load        (i_load),
        .i_store       (i_store),
        .i_funct3      (i_funct3),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_done        (o_done),
        .o_rdata       (o_rdata),
        .o_misaligned  (o_misaligned),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_ren    (o_dmem_ren),
        .o_dmem_wen    (o_dmem_wen),
        .o_dmem_mask   (o_dmem_mask),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_ready  (i_dmem_ready),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          rdly;
        int          vdly;
        logic [3:0]  emask;
        logic [31:0] ewdata;
        logic [31:0] erdata;
    } vec_t;

    typedef struct {
        int          stamp;
        int          lat;
        logic [31:0] rdata;
        logic        mis;
    } sb_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    sb_t  sb_q [$];

    int          n_chk = 0;
    int          n_pass = 0;
    int          tcnt = 0;
    bit          busy = 1'b0;
    logic [31:0] model_rdata = 32'h0;

    // current expectations for the memory model
    bit          manual = 1'b0;
    bit          cur_mem = 1'b0;
    bit          cur_ld = 1'b0;
    logic [31:0] cur_daddr = 32'h0;
    logic [3:0]  cur_mask = 4'h0;
    logic [31:0] cur_wdata = 32'h0;
    logic [31:0] cur_mrdata = 32'h0;
    int          cur_rdly = 0;
    int          cur_vdly = 0;
    int          req_cnt = 0;
    int          wait_cnt = 0;
    bit          in_wait = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic bit mis_model(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return a[0];
        return (a != 2'b00);
    endfunction

    // One clock: sample at the falling edge, check completions, then set the
    // memory response for the cycle.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        tcnt++;
        if (busy) chk("ready_low_busy", 32'(o_ready), 32'h0);
        if (o_done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'(o_done), 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("latency", 32'(tcnt - e.stamp), 32'(e.lat));
                chk("rdata", o_rdata, e.rdata);
                chk("misaligned", 32'(o_misaligned), 32'(e.mis));
                busy = 1'b0;
            end
        end
        if (manual) begin
            req_cnt = 0;
            in_wait = 1'b0;
        end else begin
            i_dmem_ready  = 1'b0;
            i_dmem_rvalid = 1'b0;
            i_dmem_rdata  = 32'hDEAD_BEEF;
            if (in_wait) begin
                if (wait_cnt == cur_vdly) begin
                    i_dmem_rvalid = 1'b1;
                    i_dmem_rdata  = cur_mrdata;
                    in_wait       = 1'b0;
                end
                wait_cnt++;
            end
            if (o_dmem_req) begin
                if (!cur_mem) begin
                    chk("unexpected_req", 32'(o_dmem_req), 32'h0);
                end else begin
                    chk("dmem_addr", o_dmem_addr, cur_daddr);
                    chk("dmem_ren", 32'(o_dmem_ren), 32'(cur_ld));
                    chk("dmem_wen", 32'(o_dmem_wen), 32'(!cur_ld));
                    if (!cur_ld) begin
                        chk("dmem_mask", 32'(o_dmem_mask), 32'(cur_mask));
                        chk("dmem_wdata", o_dmem_wdata, cur_wdata);
                    end
                    if (req_cnt == cur_rdly) begin
                        i_dmem_ready = 1'b1;
                        req_cnt      = 0;
                        if (cur_ld) begin
                            in_wait  = 1'b1;
                            wait_cnt = 0;
                        end
                    end else begin
                        req_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!o_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'h1);
    endtask

    task automatic run_vec(input vec_t v);
        bit  acc;
        bit  trap;
        sb_t e;
        int  guard;
        acc  = v.ld | v.st;
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = acc && mis_model(v.f3, v.addr[1:0]);
`endif
        wait_ready();
        cur_mem    = acc && !trap;
        cur_ld     = v.ld && !v.st;
        cur_daddr  = {v.addr[31:2], 2'b00};
        cur_mask   = v.emask;
        cur_wdata  = v.ewdata;
        cur_mrdata = v.mrdata;
        cur_rdly   = v.rdly;
        cur_vdly   = v.vdly;
        e.stamp = tcnt;
        if (!acc || trap) e.lat = 1;
        else if (v.st)    e.lat = 2 + v.rdly;
        else              e.lat = 3 + v.rdly + v.vdly;
        if (cur_mem && cur_ld) model_rdata = v.erdata;
        e.rdata = model_rdata;
        e.mis   = trap;
        sb_q.push_back(e);
        busy     = 1'b1;
        i_valid  = 1'b1;
        i_load   = v.ld;
        i_store  = v.st;
        i_funct3 = v.f3;
        i_addr   = v.addr;
        i_wdata  = v.wdata;
        tick();
        i_valid = 1'b0;
        i_load  = 1'b0;
        i_store = 1'b0;
        guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        if (busy) begin
            chk("done_timeout", 32'(busy), 32'h0);
            sb_q.delete();
            busy = 1'b0;
        end
    endtask

    initial begin
        //            ld    st    f3      addr          wdata         mrdata        rd vd mask     ewdata        erdata
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h1234_56AB, 32'h0,        0, 0, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 3, 4'b0000, 32'h0,        32'hFFFF_8001};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_3001, 32'h0,        32'h0000_F000, 0, 0, 4'b0000, 32'h0,        32'h0000_00F0};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_5002, 32'hDEAD_BEEF, 32'h0,        4, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 32'h0,        1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'h89AB_CDEF, 0, 0, 4'b0000, 32'h0,        32'h89AB_CDEF};
        vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h0000_7000, 32'h0,        32'h1234_5680, 1, 0, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h0000_7002, 32'h0,        32'hF00D_BEEF, 0, 2, 4'b0000, 32'h0,        32'h0000_F00D};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h0000_7002, 32'h0,        32'h007F_0000, 0, 0, 4'b0000, 32'h0,        32'h0000_007F};
        vecs[9]  = '{1'b0, 1'b0, 3'b010, 32'h0000_A004, 32'h1111_1111, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 1'b1, 3'b000, 32'h0000_8001, 32'h0000_005A, 32'h0,        0, 0, 4'b0010, 32'h5A5A_5A5A, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h0000_9001, 32'h0,        32'h0000_8765, 0, 0, 4'b0000, 32'h0,        32'hFFFF_8765};
        vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h0000_A000, 32'h0,        32'h1122_3344, 0, 0, 4'b0000, 32'h0,        32'h1122_3344};
        vecs[13] = '{1'b1, 1'b0, 3'b101, 32'h0000_B000, 32'h0,        32'h1234_ABCD, 2, 1, 4'b0000, 32'h0,        32'h0000_ABCD};

        i_rst         = 1'b1;
        i_valid       = 1'b0;
        i_load        = 1'b0;
        i_store       = 1'b0;
        i_funct3      = 3'b000;
        i_addr        = '0;
        i_wdata       = 32'h0;
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata  = 32'h0;

        // reset state
        tick();
        tick();
        chk("rst_ready", 32'(o_ready), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_misaligned", 32'(o_misaligned), 32'h0);
        chk("rst_req", 32'(o_dmem_req), 32'h0);
        chk("rst_ren", 32'(o_dmem_ren), 32'h0);
        chk("rst_wen", 32'(o_dmem_wen), 32'h0);
        chk("rst_mask", 32'(o_dmem_mask), 32'h0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_daddr", o_dmem_addr, 32'h0);
        chk("rst_dwdata", o_dmem_wdata, 32'h0);
        i_rst = 1'b0;
        tick();
        chk("idle_ready", 32'(o_ready), 32'h1);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // reset while waiting for read data
        wait_ready();
        manual        = 1'b1;
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_valid       = 1'b1;
        i_load        = 1'b1;
        i_funct3      = 3'b010;
        i_addr        = 32'h0000_C000;
        tick();                                   // REQ
        i_valid = 1'b0;
        i_load  = 1'b0;
        chk("rw_req", 32'(o_dmem_req), 32'h1);
        i_dmem_ready = 1'b1;
        tick();                                   // WAIT
        i_dmem_ready = 1'b0;
        chk("rw_wait_req", 32'(o_dmem_req), 32'h0);
        chk("rw_wait_ready", 32'(o_ready), 32'h0);
        i_rst = 1'b1;
        tick();                                   // IDLE after reset
        chk("rw_after_req", 32'(o_dmem_req), 32'h0);
        chk("rw_after_done", 32'(o_done), 32'h0);
        i_rst         = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hDEAD_DEAD;
        tick();
        chk("rw_idle_ready", 32'(o_ready), 32'h1);
        chk("rw_stray_done", 32'(o_done), 32'h0);
        tick();
        chk("rw_stray_done2", 32'(o_done), 32'h0);
        model_rdata = 32'h0;                      // reset cleared the held load data
        chk("rw_rdata_held", o_rdata, model_rdata);
        i_dmem_rvalid = 1'b0;
        manual        = 1'b0;

        run_vec(vecs[2]);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit sitting downstream of the ALU in the execute/memory stage: it takes the ALU-computed effective address plus store data, runs a request/response handshake with the data memory, and returns aligned, sign/zero-extended load data for writeback. It is multi-cycle. The pipeline hands it one access at a time and waits for `o_done`.

## Interface
- `ADDR_W`, 32, byte-address width of `i_addr` / `o_dmem_addr`
- `i_clk` in 1: single clock, all state on rising edge
- `i_rst` in 1: synchronous, active-high reset
- `i_valid` in 1: access request from pipeline
- `o_ready` out 1: LSU idle, can accept; `(state==IDLE) && !i_rst`
- `i_load` / `i_store` in 1: access type; store wins if both set
- `i_funct3` in 3: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- `i_addr` in ADDR_W: effective address (ALU result)
- `i_wdata` in 32: store data, low bits significant
- `o_done` out 1: one-cycle completion pulse
- `o_rdata` out 32: extended load data; valid with `o_done`, held until next load completes
- `o_misaligned` out 1: qualifies `o_done`, only with macro
- `o_dmem_req` out 1: memory request valid
- `o_dmem_addr` out ADDR_W: word-aligned address (`[1:0]`=0)
- `o_dmem_ren` / `o_dmem_wen` out 1: read / write
- `o_dmem_mask` out 4: byte-lane enables
- `o_dmem_wdata` out 32: lane-replicated store data
- `i_dmem_ready` in 1: memory accepts request this cycle
- `i_dmem_rvalid` in 1: read data valid
- `i_dmem_rdata` in 32: read data word

## Operation
- States:
  - IDLE: accept on `i_valid && o_ready`; latch addr/funct3/wdata/type.
  - Accept with neither load nor store: go to DONE, no memory access.
  - Otherwise go to REQ.
- REQ: `o_dmem_req=1` with registered addr/mask/wdata/ren/wen, held stable until `i_dmem_ready`.
  - Store accepted: go to DONE.
  - Load accepted: go to WAIT.
- WAIT: on `i_dmem_rvalid`, register the extracted data and go to DONE. `i_dmem_rvalid` is ignored in every other state.
- DONE: `o_done=1` for exactly one cycle, then IDLE.
- Store mask:
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<{addr[1],1'b0}`
  - word: `4'b1111`
- Store data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load extract: shift `i_dmem_rdata` right by `8*addr[1:0]`. Byte/half are sign-extended for 000/001 and zero-extended for 100/101. Word is passed through.
- Misaligned access: half with `addr[0]=1`, or word with `addr[1:0]!=0`.
- Reserved funct3 values (011, 110, 111) are treated as word.

## Timing
- Reset values:
  - state IDLE
  - `o_done`, `o_misaligned`, `o_dmem_req`, `o_dmem_ren`, `o_dmem_wen` = 0
  - `o_dmem_mask` = 0
  - `o_rdata`, `o_dmem_addr`, `o_dmem_wdata` = 0
- Reset mid-access: returns to IDLE next edge and drops `o_dmem_req`. No `o_done` is issued. Any late `i_dmem_rvalid` is ignored.
- Store, memory ready immediately:
  - accept at cycle 0
  - `o_dmem_req` at cycle 1
  - `o_done` at cycle 2
- Load, zero-wait memory (`rvalid` the cycle after ready): `o_done` at cycle 3.
- Each memory stall cycle adds one cycle of latency.
- `o_ready` is low from the cycle after acceptance through DONE. The earliest back-to-back accept is the cycle after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access is not issued to memory; IDLE goes directly to DONE.
  - `o_done=1` with `o_misaligned=1`.
  - `o_rdata` unchanged.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `o_misaligned` is tied 0.
  - Misaligned low address bits are ignored for half/word: mask and extract use the aligned lane (`addr[0]` cleared for half, `addr[1:0]` cleared for word).

## Structure
- `lsu_pkg`: holds the state enum (IDLE/REQ/WAIT/DONE) and the funct3 constants (LB/LH/LW/LBU/LHU).
- Sub-module `lsu_align`: purely combinational. Holds store mask/data generation and load extract/extend. The FSM lives in `lsu`.

## Test plan
- Store byte: addr `0x1003`, wdata `0xAB`, ready immediate → `o_dmem_addr=0x1000`, mask `4'b1000`, wdata `0xABABABAB`, `o_done` at cycle 2.
- Load half signed: addr `0x2002`, `rdata=0x8001_1234`, rvalid 3 cycles late → `o_rdata=0xFFFF_8001`, `o_done` at cycle 6.
- Load byte unsigned: addr `0x3001`, `rdata=0x0000_F000` → `o_rdata=0x0000_00F0`.
- `i_dmem_ready` low 4 cycles → `o_dmem_req`, addr, mask stable throughout; `o_ready=0`.
- Word load at `0x4002`:
  - with macro → `o_done` and `o_misaligned` at cycle 1, no `o_dmem_req`.
  - without macro → memory read at `0x4000`.
- Reset asserted in WAIT → IDLE next cycle, no `o_done`; a later stray rvalid is ignored; the next access proceeds normally.
